// File: rtl/conv_bias_sequencer.sv
// Streams one SRAM bias word per output channel, each held for HOLD accepted beats.
// First bias valid 3 cycles after start; bias_ready low stalls everything, no SRAM access.
module conv_bias_sequencer #(
  parameter int NUM_CH = 11,
  parameter int HOLD   = 3
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [4:0]  ch_base,
  output logic        mem_me,
  output logic [4:0]  mem_adr,
  input  logic [31:0] mem_q,
  output logic [31:0] bias_out,
  output logic        bias_valid,
  input  logic        bias_ready,
  output logic [4:0]  bias_ch,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_CH   = 5'(NUM_CH - 1);
  localparam logic [4:0] LAST_BEAT = 5'(HOLD - 1);

  state_t     state, state_nxt;
  logic [4:0] base_r;
  logic [4:0] ch_cnt;
  logic [4:0] beat_cnt;
  logic       beat_acc;
  logic       last_beat;
  logic       last_ch;

  assign beat_acc  = (state == S_PRESENT) && bias_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign last_ch   = (ch_cnt == LAST_CH);

  always_ff @(posedge clk) begin
    if (rst_b) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_PRESENT;
      S_PRESENT: if (beat_acc && last_beat) state_nxt = last_ch ? S_DONE : S_CAPTURE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // The next channel's read overlaps its predecessor's last beat, leaving a single CAPTURE bubble.
  always_comb begin
    mem_me  = 1'b0;
    mem_adr = 5'd0;
    if (!rst_b) begin
      if (state == S_FETCH) begin
        mem_me  = 1'b1;
        mem_adr = base_r + ch_cnt;
      end else if (beat_acc && last_beat && !last_ch) begin
        mem_me  = 1'b1;
        mem_adr = base_r + ch_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      base_r     <= 5'd0;
      ch_cnt     <= 5'd0;
      beat_cnt   <= 5'd0;
      bias_out   <= 32'd0;
      bias_ch    <= 5'd0;
      bias_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bias_valid <= (state_nxt == S_PRESENT);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          ch_cnt   <= 5'd0;
          beat_cnt <= 5'd0;
          if (start) base_r <= ch_base;
        end
        S_CAPTURE: begin
          bias_out <= mem_q;
          bias_ch  <= ch_cnt;
        end
        S_PRESENT: begin
          if (beat_acc) begin
            if (last_beat) begin
              beat_cnt <= 5'd0;
              if (!last_ch) ch_cnt <= ch_cnt + 5'd1;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bias_sequencer.sv
// Scoreboard bench: stimulus pushes the expected address and beat stream, a negedge monitor pops and compares.
module tb_conv_bias_sequencer;

  localparam int NUM_CH = 11;
  localparam int HOLD   = 3;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [4:0]  ch_base;
  logic        mem_me;
  logic [4:0]  mem_adr;
  logic [31:0] mem_q;
  logic [31:0] bias_out;
  logic        bias_valid;
  logic        bias_ready;
  logic [4:0]  bias_ch;
  logic        busy;
  logic        done;

  logic        e_start;
  logic [4:0]  e_base;
  logic        e_me;
  logic [4:0]  e_adr;
  logic [31:0] e_q;
  logic [31:0] e_out;
  logic        e_valid;
  logic [4:0]  e_ch;
  logic        e_busy;
  logic        e_done;

  logic [31:0] sram [32];
  logic [31:0] exp_dat [$];
  int          exp_ch  [$];
  logic [4:0]  adr_q   [$];

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc = 0;
  int n_me = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_me = -1;
  int first_vld = -1;
  int t_start = 0;
  bit bp_en = 0;
  logic        prev_me = 0;
  logic        prev_stall = 0;
  logic [31:0] prev_out = 0;
  logic [4:0]  prev_ch = 0;

  conv_bias_sequencer #(.NUM_CH(NUM_CH), .HOLD(HOLD)) u_dut (
    .clk(clk), .rst_b(rst_b), .start(start), .ch_base(ch_base),
    .mem_me(mem_me), .mem_adr(mem_adr), .mem_q(mem_q),
    .bias_out(bias_out), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .bias_ch(bias_ch), .busy(busy), .done(done)
  );

  conv_bias_sequencer #(.NUM_CH(1), .HOLD(1)) u_edge (
    .clk(clk), .rst_b(rst_b), .start(e_start), .ch_base(e_base),
    .mem_me(e_me), .mem_adr(e_adr), .mem_q(e_q),
    .bias_out(e_out), .bias_valid(e_valid), .bias_ready(1'b1),
    .bias_ch(e_ch), .busy(e_busy), .done(e_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle latency, garbage on Q whenever no read was issued.
  always @(posedge clk) begin
    mem_q <= mem_me ? sram[mem_adr] : $urandom;
    e_q   <= e_me   ? sram[e_adr]   : $urandom;
  end

  always @(posedge clk) begin
    #1;
    if (bp_en) bias_ready = ($urandom_range(0, 99) < 40);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Reference: channel c reads word (base+c) mod 32 and delivers it HOLD times tagged with c.
  task automatic push_run(input logic [4:0] b);
    for (int c = 0; c < NUM_CH; c++) begin
      logic [4:0] a;
      a = b + 5'(c);
      adr_q.push_back(a);
      for (int h = 0; h < HOLD; h++) begin
        exp_dat.push_back(sram[a]);
        exp_ch.push_back(c);
      end
    end
  endtask

  task automatic pulse_start(input logic [4:0] b);
    @(posedge clk);
    #1;
    n_me = 0; first_me = -1; first_vld = -1;
    ch_base = b;
    push_run(b);
    start = 1'b1;
    t_start = ncyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_budget", 32'(done_cnt != d0), 32'd1);
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!rst_b) begin
      if (mem_me) begin
        n_me++;
        if (first_me < 0) first_me = ncyc;
        chk("me_not_back_to_back", 32'(prev_me), 32'd0);
        chk("me_not_while_stalled", 32'(bias_valid && !bias_ready), 32'd0);
        if (adr_q.size() == 0) chk("me_expected", 32'd0, 32'd1);
        else chk("mem_adr", 32'(mem_adr), 32'(adr_q.pop_front()));
      end else if (mem_adr != 5'd0) begin
        chk("mem_adr_zero_when_idle", 32'(mem_adr), 32'd0);
      end
      if (bias_valid && first_vld < 0) first_vld = ncyc;
      if (prev_stall && bias_valid) begin
        chk("stall_bias_out_stable", bias_out, prev_out);
        chk("stall_bias_ch_stable", 32'(bias_ch), 32'(prev_ch));
      end
      if (bias_valid && bias_ready) begin
        if (exp_dat.size() == 0) chk("beat_expected", 32'd0, 32'd1);
        else begin
          chk("bias_out", bias_out, exp_dat.pop_front());
          chk("bias_ch", 32'(bias_ch), 32'(exp_ch.pop_front()));
        end
      end
      if (done) begin
        done_cyc = ncyc;
        chk("done_all_beats_seen", 32'(exp_dat.size()), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        done_cnt++;
      end
    end
    prev_me    = mem_me;
    prev_stall = bias_valid && !bias_ready;
    prev_out   = bias_out;
    prev_ch    = bias_ch;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b1; start = 1'b0; ch_base = 5'd0; bias_ready = 1'b1;
    e_start = 1'b0; e_base = 5'd0;
    for (int i = 0; i < 32; i++) sram[i] = 32'(i * 1000 - 5000);
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    #3;
    chk("rst_bias_out", bias_out, 32'd0);
    chk("rst_bias_valid", 32'(bias_valid), 32'd0);
    chk("rst_bias_ch", 32'(bias_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_me", 32'(mem_me), 32'd0);
    chk("rst_mem_adr", 32'(mem_adr), 32'd0);

    // Default run, ready held high: FETCH at cycle 1, valid at 3, DONE at 2+NUM_CH*(HOLD+1).
    // Monitor cycle index of "cycle 0" is t_start+1.
    pulse_start(5'd0);
    wait_done(200);
    chk("first_fetch_cycle", 32'(first_me - t_start), 32'd2);
    chk("first_valid_cycle", 32'(first_vld - t_start), 32'd4);
    chk("done_latency", 32'(done_cyc - t_start), 32'(3 + NUM_CH * (HOLD + 1)));
    chk("mem_me_count", 32'(n_me), 32'(NUM_CH));

    // Address wrap past 31.
    for (int i = 0; i < 32; i++) sram[i] = $urandom;
    pulse_start(5'd30);
    wait_done(200);
    chk("wrap_adr_all_issued", 32'(adr_q.size()), 32'd0);

    // Random backpressure, random bases.
    bp_en = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) sram[i] = $urandom;
      pulse_start(5'($urandom_range(0, 31)));
      wait_done(2000);
      chk("bp_mem_me_count", 32'(n_me), 32'(NUM_CH));
    end
    bp_en = 0;
    @(posedge clk);
    #1 bias_ready = 1'b1;

    // start held high through a run: ignored while busy and in DONE, honoured from IDLE.
    @(posedge clk);
    #1;
    ch_base = 5'd3;
    push_run(5'd3);
    start = 1'b1;
    wait_done(200);
    #4;
    chk("held_start_idle_no_me", 32'(mem_me), 32'd0);
    chk("held_start_idle_busy", 32'(busy), 32'd0);
    push_run(5'd3);
    @(posedge clk);
    #1 start = 1'b0;
    #3;
    chk("held_start_refetch", 32'(mem_me), 32'd1);
    wait_done(200);

    // Reset during channel 5 presentation, then a clean restart.
    for (int i = 0; i < 32; i++) sram[i] = $urandom;
    pulse_start(5'd0);
    begin
      int n;
      n = 0;
      #3;
      while (!(bias_valid && bias_ch == 5'd5) && n < 200) begin
        @(posedge clk);
        #4;
        n++;
      end
      chk("reached_ch5", 32'(bias_valid && bias_ch == 5'd5), 32'd1);
    end
    rst_b = 1'b1;
    bias_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    bias_ready = 1'b1;
    exp_dat.delete(); exp_ch.delete(); adr_q.delete();
    #3;
    chk("midrst_bias_out", bias_out, 32'd0);
    chk("midrst_bias_valid", 32'(bias_valid), 32'd0);
    chk("midrst_bias_ch", 32'(bias_ch), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mem_me", 32'(mem_me), 32'd0);
    @(posedge clk);
    #4;
    chk("midrst_stays_idle", 32'(mem_me || busy), 32'd0);
    pulse_start(5'd0);
    wait_done(200);
    chk("restart_mem_me_count", 32'(n_me), 32'(NUM_CH));

    // NUM_CH=1, HOLD=1: one beat of the most negative word, DONE 4 cycles after start.
    e_base = 5'd7;
    sram[7] = 32'h8000_0000;
    @(posedge clk);
    #1 e_start = 1'b1;
    @(posedge clk);
    #1 e_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #3;
      chk("edge_mem_me", 32'(e_me), 32'(k == 1));
      chk("edge_bias_valid", 32'(e_valid), 32'(k == 3));
      chk("edge_done", 32'(e_done), 32'(k == 4));
      chk("edge_busy", 32'(e_busy), 32'(k >= 1 && k <= 4));
      if (k == 1) chk("edge_mem_adr", 32'(e_adr), 32'd7);
      if (k == 3) begin
        chk("edge_bias_out", e_out, 32'h8000_0000);
        chk("edge_bias_ch", 32'(e_ch), 32'd0);
      end
      @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
